// File: rtl/mod_count_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_count_checker_pkg
//  Description : Shared types and helpers for the modulo-counter checker:
//                FSM state encoding, clog2, the next-value (wrap) rule and a
//                parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_count_checker_pkg;

    // Width of the internal good/bad run counters (LOCK_N/UNLOCK_N <= 15).
    localparam int c_run_w = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } mcc_state_e;

    // Ceiling log2, minimum result 1 is not enforced here (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = (value > 1) ? value - 1 : 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >>> 1;
            end
        end
        return result;
    endfunction

    // Value the counter must show after v. Anything at or above MOD-1
    // (including illegal out-of-range values) is followed by 0.
    function automatic int nxt_val(input int v, input int modulus);
        return (v >= modulus - 1) ? 0 : v + 1;
    endfunction

    // Legal parameter combination for the checker.
    function automatic bit cfg_ok(input int modulus, input int cw,
                                  input int lock_n, input int unlock_n);
        return (modulus >= 2) && (modulus <= 256) &&
               (cw == clog2(modulus)) &&
               (lock_n >= 1) && (lock_n <= 15) &&
               (unlock_n >= 1) && (unlock_n <= 15);
    endfunction

endpackage : mod_count_checker_pkg
`default_nettype wire

// File: rtl/mod_count_checker_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. When clear
//                and increment coincide, the clear is applied first and the
//                increment then counts, giving 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = '1;
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? c_one : '0;
        end else if (inc && (count_q != c_max)) begin
            count_d = count_q + c_one;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/mod_count_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mod_count_checker
//  Description : Receive-side monitor for a free-running modulo-MOD counter.
//                Acquires lock on the count sequence and flags/counts skips,
//                repeats and out-of-range values while locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_count_checker
    import mod_count_checker_pkg::*;
#(
    parameter int MOD      = 4,
    parameter int CW       = 2,
    parameter int ECW      = 8,
    parameter int LOCK_N   = 2,
    parameter int UNLOCK_N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [CW-1:0]  in_count,
    input  logic           src_rst,
    input  logic           clr_err,
    output logic           locked,
    output logic           err_pulse,
    output logic [ECW-1:0] err_count,
    output logic [CW-1:0]  expected
);

    if (!cfg_ok(MOD, CW, LOCK_N, UNLOCK_N)) begin : g_bad_cfg
        $error("mod_count_checker: illegal MOD/CW/LOCK_N/UNLOCK_N combination");
    end

    localparam logic [c_run_w-1:0] c_lock_n   = c_run_w'(LOCK_N);
    localparam logic [c_run_w-1:0] c_unlock_n = c_run_w'(UNLOCK_N);
    localparam logic [c_run_w-1:0] c_run_one  = c_run_w'(1);

    mcc_state_e         state_d,     state_q;
    logic [c_run_w-1:0] good_d,      good_q;
    logic [c_run_w-1:0] bad_d,       bad_q;
    logic [CW-1:0]      expected_d,  expected_q;
    logic               err_pulse_d, err_pulse_q;
    logic               locked_d,    locked_q;

    logic               w_in_range;
    logic               w_match;
    logic [CW-1:0]      w_nxt;
    logic               w_err_inc;

    // Sample classification: an out-of-range value can never match.
    assign w_in_range = (32'(in_count) < MOD);
    assign w_match    = w_in_range && (in_count == expected_q);
    assign w_nxt      = CW'(nxt_val(32'(in_count), MOD));

    // Next-state and output logic; only in_valid cycles without src_rst
    // advance the sequence tracking.
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        bad_d       = bad_q;
        expected_d  = expected_q;
        err_pulse_d = 1'b0;
        w_err_inc   = 1'b0;

        if (src_rst) begin
            // Upstream counter restarts at 0 on its next cycle.
            expected_d = '0;
        end else if (in_valid) begin
            // Every accepted sample resyncs the expectation to what was seen.
            expected_d = w_nxt;
            case (state_q)
                UNLOCKED: begin
                    good_d = c_run_one;
                    if (c_lock_n == c_run_one) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (w_match) begin
                        good_d = good_q + c_run_one;
                        if ((good_q + c_run_one) == c_lock_n) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        // Restart acquisition from this sample, silently.
                        good_d = c_run_one;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        w_err_inc   = 1'b1;
                        bad_d       = bad_q + c_run_one;
                        if ((bad_q + c_run_one) == c_unlock_n) begin
                            state_d = UNLOCKED;
                        end
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            good_q      <= '0;
            bad_q       <= '0;
            expected_q  <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            expected_q  <= expected_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    sat_counter #(
        .WIDTH (ECW)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err_inc),
        .clr   (clr_err),
        .count (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign expected  = expected_q;

endmodule : mod_count_checker
`default_nettype wire

// File: doc/mod_count_checker.md
Name: mod_count_checker

Overview:
- Receive-side monitor for the free-running modulo-MOD up-counter output (default mod-4, 2-bit).
- Samples the counter value on a valid strobe and acquires lock on the count sequence.
- Flags and counts sequence errors: skips, repeats and out-of-range values.
- Sits downstream of any mod counter in the design. Used in benches and silicon debug to prove the counter increments by exactly 1 and wraps MOD-1 -> 0.

Parameters:
- MOD, 4, counter modulus; legal range 2..256.
- CW, 2, width of the sampled count; must equal clog2(MOD).
- ECW, 8, width of the saturating error counter.
- LOCK_N, 2, consecutive correct samples needed to enter LOCKED; range 1..15.
- UNLOCK_N, 2, consecutive mismatches in LOCKED that drop lock; range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_count is valid this cycle.
- in_count  in  CW  sampled counter value.
- src_rst  in  1  upstream counter is being reset this cycle.
- clr_err  in  1  clears err_count.
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  ECW  saturating count of LOCKED mismatches.
- expected  out  CW  value expected at the next valid sample.

Behaviour:
- Clock and reset:
  - Reset is rst, synchronous, active-high; clock is clk.
  - rst overrides every other input.
  - On reset: state=UNLOCKED, locked=0, err_pulse=0, err_count=0, expected=0, internal good/bad counters=0.
  - Reset asserted mid-acquire or mid-lock abandons the state with no error pulse.
- Outputs and next-value rule:
  - All outputs are registered. Each reflects the sample taken at edge N from edge N onward, i.e. 1-cycle latency.
  - nxt(v) = 0 if v >= MOD-1 (this covers wrap and out-of-range values), otherwise v+1.
- Match rule: in_count == expected. Any value >= MOD is always a mismatch.
- src_rst=1 (priority over in_valid):
  - The sample is ignored.
  - expected <= 0. State, good/bad counters and err_count are unchanged; no pulse.
  - This matches the upstream counter showing 0 on its first cycle after reset.
- in_valid=0: nothing changes except err_pulse <= 0.
- State machine (only in_valid=1 with src_rst=0 cycles advance it):
  - UNLOCKED:
    - expected <= nxt(in_count), good <= 1.
    - Go to LOCKED if LOCK_N==1, otherwise to ACQUIRE.
  - ACQUIRE, on match:
    - good++ and expected <= nxt(in_count).
    - When good reaches LOCK_N, go to LOCKED with bad <= 0.
  - ACQUIRE, on mismatch:
    - Re-capture: expected <= nxt(in_count), good <= 1. Stay in ACQUIRE.
    - No err_pulse, err_count unchanged.
  - LOCKED, on match: bad <= 0, expected <= nxt(in_count).
  - LOCKED, on mismatch:
    - err_pulse <= 1, err_count increments (saturates at all-ones), bad++.
    - expected <= nxt(in_count), i.e. resync to the observed value.
    - When bad reaches UNLOCK_N, go to UNLOCKED with locked <= 0.
- err_pulse is high for exactly one cycle per mismatch. Back-to-back mismatches give back-to-back high cycles.
- clr_err:
  - Alone: err_count <= 0.
  - Same cycle as an increment: err_count <= 1 (clear first, then count).
  - Never affects state or err_pulse.
- Saturation: at all-ones, err_count holds; err_pulse still fires.

Decomposition:
- Shared package holds:
  - State enum (UNLOCKED=2'd0, ACQUIRE=2'd1, LOCKED=2'd2).
  - A clog2 helper function.
  - A parameter check: CW == clog2(MOD).
- One natural sub-module, sat_counter: parameterised width, with inc, clr and clear-then-count priority.
  - Instantiated for err_count.
  - Reusable elsewhere in the codebase.
- The nxt() wrap function lives in the package.

Test Plan:
- Reset, then in_valid every cycle with in_count 0,1,2,3,0,1 (MOD=4) -> locked=1 one cycle after the 2nd sample; err_count stays 0; expected tracks 2,3,0,1,2 after lock.
- Locked; sequence 2,3,1,2 (skip 0) -> err_pulse one cycle after sample "1", err_count=1, expected=2; the next match clears bad; locked stays 1.
- Locked; samples 1,1,1 (repeats) -> two pulses, err_count=2, locked drops after the 2nd mismatch; the third sample starts acquire with expected=2.
- Locked at expected=3; pulse src_rst, then valid samples 0,1 -> no error; expected=2; locked remains 1.
- Mismatches with err_count=8'hFE, three more errors -> 8'hFF, holds at 8'hFF; assert clr_err concurrently with an error -> err_count=1.
- rst asserted during ACQUIRE with good=1 -> next cycle locked=0, expected=0, err_pulse=0; gapped in_valid (idle cycles between samples) -> no state change on idle cycles.
